// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI write-path encodings, state enum and helpers
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] bytes;
  logic [AW-1:0] aligned;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] total;
  logic [AW-1:0] wrap_mask;

  // Align the current address to the beat size, step one beat, then fold into the wrap window
  always_comb begin
    bytes     = ONE << size;
    aligned   = addr & ~(bytes - ONE);
    incr_addr = aligned + bytes;
    total     = ({{(AW-8){1'b0}}, len} + ONE) << size;
    wrap_mask = total - ONE;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      // Reserved bursts never write memory, so any progression is acceptable; reuse INCR
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave.sv
// rtl/axi_wr_slave.sv - AXI4 write slave endpoint driving a simple memory write port
module axi_wr_slave
  import axi_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int MAX_SIZE = 3
) (
  input  logic            axi_aclk,
  input  logic            rst,
  input  logic [AW-1:0]   axi_awaddr,
  input  logic [7:0]      axi_awlen,
  input  logic [2:0]      axi_awsize,
  input  logic [1:0]      axi_awburst,
  input  logic            axi_awvalid,
  output logic            axi_awready,
  input  logic [DW-1:0]   axi_wdata,
  input  logic [DW/8-1:0] axi_wstrb,
  input  logic            axi_wlast,
  input  logic            axi_wvalid,
  output logic            axi_wready,
  output logic [1:0]      axi_bresp,
  output logic            axi_bvalid,
  input  logic            axi_bready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb
);

  localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);

  state_t        state_q;
  logic          awready_q;
  logic          wready_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    len_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q;
  logic [7:0]    beat_cnt_q;
  logic          err_q;

  logic [7:0]    beat_cnt_d;
  logic          err_d;
  logic [AW-1:0] next_addr;
  logic          w_hs;
  logic          beat_last;
  logic          mismatch;
  logic          illegal_aw;

  axi_burst_addr_gen #(
    .AW(AW)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Per-beat decode: handshake, expected-last, wlast mismatch and AW legality
  always_comb begin
    w_hs       = axi_wvalid && wready_q;
    beat_last  = (beat_cnt_q == len_q);
    mismatch   = (axi_wlast != beat_last);
    beat_cnt_d = beat_cnt_q + 8'd1;
    err_d      = err_q || mismatch;
    illegal_aw = (axi_awburst == BURST_RSVD) ||
                 (axi_awsize > MAX_SIZE_L) ||
                 ((axi_awburst == BURST_WRAP) && !wrap_len_ok(axi_awlen));
  end

  // Burst FSM: address capture, beat counting/addressing and B response, all outputs registered
  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      addr_q     <= '0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      beat_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (axi_awvalid && awready_q) begin
            addr_q     <= axi_awaddr;
            len_q      <= axi_awlen;
            size_q     <= axi_awsize;
            burst_q    <= axi_awburst;
            beat_cnt_q <= 8'd0;
            err_q      <= illegal_aw;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= next_addr;
            err_q      <= err_d;
            // Termination follows the len count only; wlast merely flags errors
            if (beat_last) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= err_d ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;

  // Zero-latency write port: a beat commits only if the burst and this beat are both clean
  assign mem_we    = w_hs && !err_q && !mismatch;
  assign mem_addr  = addr_q;
  assign mem_wdata = axi_wdata;
  assign mem_wstrb = axi_wstrb;

endmodule

// File: tb/tb_axi_wr_slave.sv
// tb/tb_axi_wr_slave.sv - directed self-checking bench for axi_wr_slave
module tb_axi_wr_slave;

  logic        axi_aclk;
  logic        rst;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  int n_vec;
  int n_err;

  logic        obs_awready_idle;
  logic        obs_awready_data;
  logic        obs_wready [0:15];
  logic [31:0] obs_addr   [0:15];
  logic        obs_we     [0:15];
  logic [63:0] obs_wdata  [0:15];
  logic [7:0]  obs_wstrb  [0:15];
  logic        obs_bvalid;
  logic [1:0]  obs_bresp;
  logic        obs_b_stable;
  logic        obs_bvalid_after;
  logic        obs_awready_after;

  axi_wr_slave #(
    .AW(32),
    .DW(64),
    .MAX_SIZE(3)
  ) dut (
    .axi_aclk    (axi_aclk),
    .rst         (rst),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  // Drives one complete burst back-to-back and records what the DUT showed on each beat
  task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input int wl_idx, input int hold);
    @(negedge axi_aclk);
    axi_awaddr  = a;
    axi_awlen   = l;
    axi_awsize  = s;
    axi_awburst = b;
    axi_awvalid = 1'b1;
    #1 obs_awready_idle = axi_awready;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      axi_wvalid = 1'b1;
      axi_wdata  = 64'hD000_0000_0000_0000 + 64'(i);
      axi_wstrb  = 8'hF0 ^ 8'(i);
      axi_wlast  = (i == wl_idx);
      #1;
      if (i == 0) obs_awready_data = axi_awready;
      if (i < 16) begin
        obs_wready[i] = axi_wready;
        obs_addr[i]   = mem_addr;
        obs_we[i]     = mem_we;
        obs_wdata[i]  = mem_wdata;
        obs_wstrb[i]  = mem_wstrb;
      end
      @(posedge axi_aclk);
      @(negedge axi_aclk);
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
    #1;
    obs_bvalid   = axi_bvalid;
    obs_bresp    = axi_bresp;
    obs_b_stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge axi_aclk);
      #1;
      if (axi_bvalid !== 1'b1 || axi_bresp !== obs_bresp || axi_awready !== 1'b0 || axi_wready !== 1'b0)
        obs_b_stable = 1'b0;
    end
    axi_bready = 1'b1;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    axi_bready = 1'b0;
    #1;
    obs_bvalid_after  = axi_bvalid;
    obs_awready_after = axi_awready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    axi_wvalid = 1'b1;
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    n_vec++; if (axi_awready !== 1'b1) begin n_err++; $display("FAIL reset_awready got %b want 1", axi_awready); end
    n_vec++; if (axi_wready !== 1'b0) begin n_err++; $display("FAIL reset_wready got %b want 0", axi_wready); end
    n_vec++; if (axi_bvalid !== 1'b0) begin n_err++; $display("FAIL reset_bvalid got %b want 0", axi_bvalid); end
    n_vec++; if (axi_bresp !== 2'b00) begin n_err++; $display("FAIL reset_bresp got %b want 00", axi_bresp); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    axi_wvalid = 1'b0;
    rst = 1'b0;
    @(negedge axi_aclk);
    #1;
    n_vec++; if (axi_wready !== 1'b0) begin n_err++; $display("FAIL idle_wready got %b want 0", axi_wready); end
  endtask

  task automatic test_incr();
    logic [31:0] exp_a [0:3];
    exp_a = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
    run_burst(32'h1000, 8'd3, 3'd3, 2'b01, 3, 0);
    n_vec++; if (obs_awready_idle !== 1'b1) begin n_err++; $display("FAIL incr_awready_idle got %b want 1", obs_awready_idle); end
    n_vec++; if (obs_awready_data !== 1'b0) begin n_err++; $display("FAIL incr_awready_data got %b want 0", obs_awready_data); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (obs_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL incr_addr[%0d] got %h want %h", i, obs_addr[i], exp_a[i]); end
      n_vec++; if (obs_we[i] !== 1'b1) begin n_err++; $display("FAIL incr_we[%0d] got %b want 1", i, obs_we[i]); end
      n_vec++; if (obs_wready[i] !== 1'b1) begin n_err++; $display("FAIL incr_wready[%0d] got %b want 1", i, obs_wready[i]); end
    end
    n_vec++; if (obs_wdata[2] !== 64'hD000_0000_0000_0002) begin n_err++; $display("FAIL incr_wdata got %h want d000000000000002", obs_wdata[2]); end
    n_vec++; if (obs_wstrb[3] !== 8'hF3) begin n_err++; $display("FAIL incr_wstrb got %h want f3", obs_wstrb[3]); end
    n_vec++; if (obs_bvalid !== 1'b1) begin n_err++; $display("FAIL incr_bvalid got %b want 1", obs_bvalid); end
    n_vec++; if (obs_bresp !== 2'b00) begin n_err++; $display("FAIL incr_bresp got %b want 00", obs_bresp); end
    n_vec++; if (obs_bvalid_after !== 1'b0) begin n_err++; $display("FAIL incr_bvalid_after got %b want 0", obs_bvalid_after); end
    n_vec++; if (obs_awready_after !== 1'b1) begin n_err++; $display("FAIL incr_awready_after got %b want 1", obs_awready_after); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [0:3];
    exp_a = '{32'h1018, 32'h1000, 32'h1008, 32'h1010};
    run_burst(32'h1018, 8'd3, 3'd3, 2'b10, 3, 0);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (obs_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr[%0d] got %h want %h", i, obs_addr[i], exp_a[i]); end
      n_vec++; if (obs_we[i] !== 1'b1) begin n_err++; $display("FAIL wrap_we[%0d] got %b want 1", i, obs_we[i]); end
    end
    n_vec++; if (obs_bresp !== 2'b00) begin n_err++; $display("FAIL wrap_bresp got %b want 00", obs_bresp); end
  endtask

  task automatic test_unaligned();
    run_burst(32'h2003, 8'd1, 3'd2, 2'b01, 1, 0);
    n_vec++; if (obs_addr[0] !== 32'h2003) begin n_err++; $display("FAIL unal_addr0 got %h want 00002003", obs_addr[0]); end
    n_vec++; if (obs_addr[1] !== 32'h2004) begin n_err++; $display("FAIL unal_addr1 got %h want 00002004", obs_addr[1]); end
    n_vec++; if (obs_bresp !== 2'b00) begin n_err++; $display("FAIL unal_bresp got %b want 00", obs_bresp); end
  endtask

  task automatic test_fixed();
    run_burst(32'h3008, 8'd2, 3'd3, 2'b00, 2, 0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (obs_addr[i] !== 32'h3008) begin n_err++; $display("FAIL fixed_addr[%0d] got %h want 00003008", i, obs_addr[i]); end
    end
  endtask

  task automatic test_wlast_early();
    logic exp_we [0:3];
    exp_we = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_burst(32'h4000, 8'd3, 3'd3, 2'b01, 1, 0);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (obs_we[i] !== exp_we[i]) begin n_err++; $display("FAIL early_we[%0d] got %b want %b", i, obs_we[i], exp_we[i]); end
      n_vec++; if (obs_wready[i] !== 1'b1) begin n_err++; $display("FAIL early_wready[%0d] got %b want 1", i, obs_wready[i]); end
    end
    n_vec++; if (obs_bvalid !== 1'b1) begin n_err++; $display("FAIL early_bvalid got %b want 1", obs_bvalid); end
    n_vec++; if (obs_bresp !== 2'b10) begin n_err++; $display("FAIL early_bresp got %b want 10", obs_bresp); end
  endtask

  task automatic test_wlast_missing();
    run_burst(32'h4100, 8'd1, 3'd3, 2'b01, 99, 0);
    n_vec++; if (obs_we[0] !== 1'b1) begin n_err++; $display("FAIL miss_we0 got %b want 1", obs_we[0]); end
    n_vec++; if (obs_we[1] !== 1'b0) begin n_err++; $display("FAIL miss_we1 got %b want 0", obs_we[1]); end
    n_vec++; if (obs_bresp !== 2'b10) begin n_err++; $display("FAIL miss_bresp got %b want 10", obs_bresp); end
  endtask

  task automatic test_illegal_aw();
    run_burst(32'h5000, 8'd0, 3'd3, 2'b11, 0, 0);
    n_vec++; if (obs_wready[0] !== 1'b1) begin n_err++; $display("FAIL rsvd_wready got %b want 1", obs_wready[0]); end
    n_vec++; if (obs_we[0] !== 1'b0) begin n_err++; $display("FAIL rsvd_we got %b want 0", obs_we[0]); end
    n_vec++; if (obs_bresp !== 2'b10) begin n_err++; $display("FAIL rsvd_bresp got %b want 10", obs_bresp); end
    run_burst(32'h5100, 8'd2, 3'd3, 2'b10, 2, 0);
    n_vec++; if (obs_we[0] !== 1'b0) begin n_err++; $display("FAIL wraplen_we got %b want 0", obs_we[0]); end
    n_vec++; if (obs_bresp !== 2'b10) begin n_err++; $display("FAIL wraplen_bresp got %b want 10", obs_bresp); end
    run_burst(32'h5200, 8'd0, 3'd4, 2'b01, 0, 0);
    n_vec++; if (obs_we[0] !== 1'b0) begin n_err++; $display("FAIL size_we got %b want 0", obs_we[0]); end
    n_vec++; if (obs_bresp !== 2'b10) begin n_err++; $display("FAIL size_bresp got %b want 10", obs_bresp); end
  endtask

  task automatic test_back_to_back();
    run_burst(32'h6000, 8'd0, 3'd3, 2'b11, 0, 0);
    run_burst(32'h6100, 8'd0, 3'd3, 2'b01, 0, 0);
    n_vec++; if (obs_awready_idle !== 1'b1) begin n_err++; $display("FAIL b2b_awready got %b want 1", obs_awready_idle); end
    n_vec++; if (obs_we[0] !== 1'b1) begin n_err++; $display("FAIL b2b_we got %b want 1", obs_we[0]); end
    n_vec++; if (obs_bresp !== 2'b00) begin n_err++; $display("FAIL b2b_bresp got %b want 00", obs_bresp); end
  endtask

  task automatic test_bready_hold();
    run_burst(32'h7000, 8'd0, 3'd3, 2'b11, 0, 5);
    n_vec++; if (obs_b_stable !== 1'b1) begin n_err++; $display("FAIL hold_stable got %b want 1", obs_b_stable); end
    n_vec++; if (obs_bresp !== 2'b10) begin n_err++; $display("FAIL hold_bresp got %b want 10", obs_bresp); end
    n_vec++; if (obs_bvalid_after !== 1'b0) begin n_err++; $display("FAIL hold_bvalid_after got %b want 0", obs_bvalid_after); end
    n_vec++; if (obs_awready_after !== 1'b1) begin n_err++; $display("FAIL hold_awready_after got %b want 1", obs_awready_after); end
  endtask

  task automatic test_reset_mid();
    @(negedge axi_aclk);
    axi_awaddr  = 32'h8000;
    axi_awlen   = 8'd3;
    axi_awsize  = 3'd3;
    axi_awburst = 2'b01;
    axi_awvalid = 1'b1;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b1;
    axi_wlast   = 1'b0;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    #1 rst = 1'b1;
    #1;
    n_vec++; if (axi_awready !== 1'b1) begin n_err++; $display("FAIL rstmid_awready got %b want 1", axi_awready); end
    n_vec++; if (axi_wready !== 1'b0) begin n_err++; $display("FAIL rstmid_wready got %b want 0", axi_wready); end
    n_vec++; if (axi_bvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_bvalid got %b want 0", axi_bvalid); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rstmid_mem_we got %b want 0", mem_we); end
    axi_wvalid = 1'b0;
    @(negedge axi_aclk);
    rst = 1'b0;
    run_burst(32'h9000, 8'd0, 3'd3, 2'b01, 0, 0);
    n_vec++; if (obs_addr[0] !== 32'h9000) begin n_err++; $display("FAIL rstmid_next_addr got %h want 00009000", obs_addr[0]); end
    n_vec++; if (obs_we[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_next_we got %b want 1", obs_we[0]); end
    n_vec++; if (obs_bresp !== 2'b00) begin n_err++; $display("FAIL rstmid_next_bresp got %b want 00", obs_bresp); end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    axi_awaddr  = '0;
    axi_awlen   = '0;
    axi_awsize  = '0;
    axi_awburst = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wlast   = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_unaligned();
    test_fixed();
    test_wlast_early();
    test_wlast_missing();
    test_illegal_aw();
    test_back_to_back();
    test_bready_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_wr_slave.md
Name: axi_wr_slave

Overview:
AXI4 write-side slave endpoint that consumes the AW/W/B master signals produced by the axi_protocol write FSM.
- Accepts one write address per burst and generates the per-beat byte address for FIXED, INCR and WRAP bursts.
- Presents each accepted data beat on a simple memory write port.
- Checks burst legality and wlast placement, then returns a single B response per burst.
- Sits between the master FSM and the memory/register model used in the write-path verification environment.

Parameters:
AW, 32, address width in bits
DW, 64, data width in bits; strobe width is DW/8
MAX_SIZE, 3, largest legal awsize (log2(DW/8))

Ports:
axi_aclk  in  1  clock
rst  in  1  asynchronous active-high reset
axi_awaddr  in  AW  burst start byte address
axi_awlen  in  8  beats minus one
axi_awsize  in  3  log2 bytes per beat
axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
axi_awvalid  in  1  address valid
axi_awready  out  1  address accepted
axi_wdata  in  DW  write data
axi_wstrb  in  DW/8  byte strobes
axi_wlast  in  1  master's last-beat flag
axi_wvalid  in  1  data valid
axi_wready  out  1  slave ready for data
axi_bresp  out  2  00 OKAY, 10 SLVERR
axi_bvalid  out  1  response valid
axi_bready  in  1  master accepts response
mem_we  out  1  write strobe, one per committed good beat
mem_addr  out  AW  byte address of current beat
mem_wdata  out  DW  beat data
mem_wstrb  out  DW/8  beat strobes

Behaviour:
Interface: one clock axi_aclk; reset rst is asynchronous, active-high. On rst assertion, all state is forced immediately to the reset values below.

Reset values:
- axi_awready=1, axi_wready=0, axi_bvalid=0, axi_bresp=00, mem_we=0.
- State=IDLE, beat_cnt=0, err=0.

States:
- IDLE: axi_awready=1.
  - On AW handshake (awvalid&&awready): capture addr/len/size/burst into registers, clear beat_cnt and err.
  - Next cycle: axi_awready=0, axi_wready=1, state DATA.
- DATA: axi_wready=1.
  - Each W handshake increments beat_cnt (8-bit).
  - Beat is expected-last when beat_cnt==len.
  - On the expected-last handshake: axi_wready=0, axi_bvalid=1, state RESP (registered, next cycle).
- RESP: axi_bvalid and axi_bresp are held stable until axi_bready.
  - On B handshake: axi_bvalid=0, axi_awready=1, state IDLE (next cycle).
  - Min burst-to-burst turnaround: AW at cycle t, single beat at t+1, B at t+2, awready at t+3.

Error rules (err is sticky per burst; any error gives bresp=10, otherwise 00):
- Illegal AW, detected at capture; all beats of the burst are still accepted, but mem_we is suppressed for the whole burst:
  - awburst=11
  - awsize>MAX_SIZE
  - WRAP with len not in {1,3,7,15}
- wlast mismatch:
  - axi_wlast=1 on a beat with beat_cnt!=len, or axi_wlast=0 on the expected-last beat, sets err.
  - mem_we is suppressed from the mismatching beat onward.
  - The burst always terminates on the len-count, never on wlast.

Memory port:
- mem_we = wvalid&&wready&&!err&&!mismatch_this_beat. This is combinational (zero latency).
- mem_addr comes from the beat-address register; mem_wdata and mem_wstrb pass through from axi_wdata and axi_wstrb.

Address generation (bytes=1<<size, applied after each handshake):
- FIXED: address unchanged.
- INCR: next = (addr & ~(bytes-1)) + bytes. This aligns an unaligned start from beat 2 onward; the sum wraps modulo 2^AW.
- WRAP: total = bytes*(len+1); lower = addr & ~(total-1); next = lower | ((aligned_addr+bytes) & (total-1)).

Other boundaries:
- awvalid outside IDLE is ignored; awready stays low.
- wvalid in IDLE or RESP is ignored; wready stays low.
- The master must not drop valid before ready. The slave does not check this.
- rst mid-burst or mid-RESP returns to IDLE; no B is issued for the aborted burst.

Decomposition:
- Package axi_pkg holds:
  - burst encodings FIXED/INCR/WRAP/RSVD
  - response encodings OKAY/SLVERR
  - the 2-bit state enum IDLE/DATA/RESP
- One combinational sub-module, axi_burst_addr_gen, with inputs addr, size, len, burst and output next_addr. It is reused by the future read-side slave.

Test Plan:
- INCR, addr 0x1000, len 3, size 3, wlast on beat 4 -> mem_addr 0x1000/0x1008/0x1010/0x1018, four mem_we pulses, bresp 00.
- WRAP, addr 0x1018, len 3, size 3 -> mem_addr 0x1018, 0x1000, 0x1008, 0x1010; bresp 00.
- INCR unaligned, addr 0x2003, len 1, size 2 -> mem_addr 0x2003 then 0x2004.
- INCR len 3, wlast on beat 2 -> mem_we on beat 1 only, four beats accepted, bresp 10.
- awburst=11 with len 0 -> one beat accepted, no mem_we, bresp 10.
- bready held low 5 cycles in RESP -> bvalid/bresp stable, awready 0; rst asserted in DATA -> awready 1, wready 0, bvalid 0 immediately.
